// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared constants and lane record layout for the instruction queue
package inst_queue_pkg;

  // Invalid output lanes present this word so that ID sees a harmless NOP.
  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int DEPTH_DEF = 8;

  // Stored lane record: {adel, pc[31:0], inst[31:0]}.
  localparam int LANE_W = 65;

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] inst;
  } lane_t;

endpackage

// File: rtl/inst_queue_ram.sv
// rtl/inst_queue_ram.sv - DEPTH x 65 register file, two write ports, two read ports
//
// Ports:
//   clk                         rising-edge clock
//   i_we0/i_waddr0/i_wdata0     write port 0 (tail slot)
//   i_we1/i_waddr1/i_wdata1     write port 1 (tail+1 slot)
//   i_raddr0 -> o_rdata0        combinational read port 0 (head)
//   i_raddr1 -> o_rdata1        combinational read port 1 (head+1)
// Storage is not reset; the owner tracks validity through its occupancy count.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     i_we0,
  input  logic [$clog2(DEPTH)-1:0] i_waddr0,
  input  logic [LANE_W-1:0]        i_wdata0,
  input  logic                     i_we1,
  input  logic [$clog2(DEPTH)-1:0] i_waddr1,
  input  logic [LANE_W-1:0]        i_wdata1,
  input  logic [$clog2(DEPTH)-1:0] i_raddr0,
  output logic [LANE_W-1:0]        o_rdata0,
  input  logic [$clog2(DEPTH)-1:0] i_raddr1,
  output logic [LANE_W-1:0]        o_rdata1
);

  logic [LANE_W-1:0] r_mem [DEPTH];

  // The two write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-lane instruction queue between fetch stage 2 and decode/issue
//
// Optional feature macro: INST_QUEUE_BYPASS_EN (empty-queue input-to-output bypass).
//
// Ports:
//   clk, reset (async, active-low)
//   flush                         drop all entries and this cycle's enqueue/dequeue
//   in_valid/inst/pc/adel_1,2     fetched pair, lane 1 is older
//   in_ready                      at least two free entries
//   deq_num                       instructions consumed by ID this cycle (3 acts as 2)
//   out_valid/inst/pc/adel_1,2    two oldest entries, zeros when invalid
//   count                         occupancy
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid_1,
  input  logic [31:0]                in_inst_1,
  input  logic [31:0]                in_pc_1,
  input  logic                       in_adel_1,
  input  logic                       in_valid_2,
  input  logic [31:0]                in_inst_2,
  input  logic [31:0]                in_pc_2,
  input  logic                       in_adel_2,
  output logic                       in_ready,
  input  logic [1:0]                 deq_num,
  output logic                       out_valid_1,
  output logic [31:0]                out_inst_1,
  output logic [31:0]                out_pc_1,
  output logic                       out_adel_1,
  output logic                       out_valid_2,
  output logic [31:0]                out_inst_2,
  output logic [31:0]                out_pc_2,
  output logic                       out_adel_2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  lane_t      w_lane_1, w_lane_2, w_c0, w_c1, w_wdata0, w_rd0, w_rd1, w_o1, w_o2;
  logic [1:0] w_enq, w_enq_eff, w_deq_req, w_skip, w_qdeq, w_wr_cnt;
  logic       w_in_ready, w_accept, w_bypass, w_v1, w_v2;

  assign w_lane_1 = {in_adel_1, in_pc_1, in_inst_1};
  assign w_lane_2 = {in_adel_2, in_pc_2, in_inst_2};

  // Compaction: the older valid lane always lands in slot 0.
  assign w_c0 = in_valid_1 ? w_lane_1 : w_lane_2;
  assign w_c1 = w_lane_2;

  assign w_enq      = {1'b0, in_valid_1} + {1'b0, in_valid_2};
  assign w_deq_req  = (deq_num == 2'd3) ? 2'd2 : deq_num;
  assign w_in_ready = (r_count <= (PTR_W+1)'(DEPTH - 2));
  assign w_accept   = w_in_ready && !flush;
  assign w_enq_eff  = w_accept ? w_enq : 2'd0;

`ifdef INST_QUEUE_BYPASS_EN
  assign w_bypass = (r_count == '0) && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // While bypassing, ID consumes straight from the input lanes (w_skip) and
  // the queue itself is empty, so nothing is dequeued from storage.
  assign w_skip   = w_bypass ? ((w_deq_req > w_enq) ? w_enq : w_deq_req) : 2'd0;
  assign w_qdeq   = w_bypass ? 2'd0 :
                    (((PTR_W+1)'(w_deq_req) > r_count) ? r_count[1:0] : w_deq_req);
  assign w_wr_cnt = w_enq_eff - w_skip;

  // A bypass that consumed one lane stores only the younger one.
  assign w_wdata0 = (w_skip == 2'd0) ? w_c0 : w_c1;

  inst_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .i_we0    (w_wr_cnt != 2'd0),
    .i_waddr0 (r_tail),
    .i_wdata0 (w_wdata0),
    .i_we1    (w_wr_cnt == 2'd2),
    .i_waddr1 (r_tail + PTR_W'(1)),
    .i_wdata1 (w_c1),
    .i_raddr0 (r_head),
    .o_rdata0 (w_rd0),
    .i_raddr1 (r_head + PTR_W'(1)),
    .o_rdata1 (w_rd1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_qdeq);
      r_tail  <= r_tail + PTR_W'(w_wr_cnt);
      r_count <= r_count + (PTR_W+1)'(w_wr_cnt) - (PTR_W+1)'(w_qdeq);
    end
  end

  always_comb begin
    w_v1 = 1'b0;
    w_v2 = 1'b0;
    w_o1 = w_rd0;
    w_o2 = w_rd1;
    if (w_bypass) begin
      w_v1 = in_valid_1 | in_valid_2;
      w_v2 = in_valid_1 & in_valid_2;
      w_o1 = w_c0;
      w_o2 = w_c1;
    end else begin
      w_v1 = (r_count != '0);
      w_v2 = (r_count >= (PTR_W+1)'(2));
    end
  end

  assign in_ready    = w_in_ready;
  assign count       = r_count;
  assign out_valid_1 = w_v1;
  assign out_inst_1  = w_v1 ? w_o1.inst : NOP;
  assign out_pc_1    = w_v1 ? w_o1.pc   : 32'h0;
  assign out_adel_1  = w_v1 & w_o1.adel;
  assign out_valid_2 = w_v2;
  assign out_inst_2  = w_v2 ? w_o2.inst : NOP;
  assign out_pc_2    = w_v2 ? w_o2.pc   : 32'h0;
  assign out_adel_2  = w_v2 & w_o2.adel;

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard testbench for inst_queue (base build)
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid_1, in_adel_1, in_valid_2, in_adel_2;
  logic [31:0] in_inst_1, in_pc_1, in_inst_2, in_pc_2;
  logic        in_ready;
  logic [1:0]  deq_num;
  logic        out_valid_1, out_adel_1, out_valid_2, out_adel_2;
  logic [31:0] out_inst_1, out_pc_1, out_inst_2, out_pc_2;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] sb[$];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid_1  (in_valid_1),
    .in_inst_1   (in_inst_1),
    .in_pc_1     (in_pc_1),
    .in_adel_1   (in_adel_1),
    .in_valid_2  (in_valid_2),
    .in_inst_2   (in_inst_2),
    .in_pc_2     (in_pc_2),
    .in_adel_2   (in_adel_2),
    .in_ready    (in_ready),
    .deq_num     (deq_num),
    .out_valid_1 (out_valid_1),
    .out_inst_1  (out_inst_1),
    .out_pc_1    (out_pc_1),
    .out_adel_1  (out_adel_1),
    .out_valid_2 (out_valid_2),
    .out_inst_2  (out_inst_2),
    .out_pc_2    (out_pc_2),
    .out_adel_2  (out_adel_2),
    .count       (count)
  );

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] mk(input logic [31:0] pc, input logic adel);
    return {adel, pc, pc ^ 32'h1357_9bdf};
  endfunction

  task automatic compare_outputs();
    logic [64:0] e1, e2;
    int          sz;
    sz = sb.size();
    e1 = (sz >= 1) ? sb[0] : 65'h0;
    e2 = (sz >= 2) ? sb[1] : 65'h0;
    chk("count",    65'(count),       65'(sz));
    chk("in_ready", 65'(in_ready),    65'(sz <= 6));
    chk("valid_1",  65'(out_valid_1), 65'(sz >= 1));
    chk("lane_1",   {out_adel_1, out_pc_1, out_inst_1}, e1);
    chk("valid_2",  65'(out_valid_2), 65'(sz >= 2));
    chk("lane_2",   {out_adel_2, out_pc_2, out_inst_2}, e2);
  endtask

  // Drive one cycle of stimulus, update the model, then compare after the edge.
  task automatic step(input logic v1, input logic [64:0] l1,
                      input logic v2, input logic [64:0] l2,
                      input logic [1:0] dq, input logic fl);
    int sz, d;
    in_valid_1 = v1; {in_adel_1, in_pc_1, in_inst_1} = l1;
    in_valid_2 = v2; {in_adel_2, in_pc_2, in_inst_2} = l2;
    deq_num    = dq;
    flush      = fl;
    sz = sb.size();
    if (fl) begin
      sb.delete();
    end else begin
      d = (dq == 2'd3) ? 2 : int'(dq);
      if (d > sz) d = sz;
      repeat (d) void'(sb.pop_front());
      if (sz <= 6) begin
        if (v1) sb.push_back(l1);
        if (v2) sb.push_back(l2);
      end
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input logic [1:0] dq);
    step(1'b0, 65'h0, 1'b0, 65'h0, dq, 1'b0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; deq_num = 2'd0;
    in_valid_1 = 1'b0; in_inst_1 = '0; in_pc_1 = '0; in_adel_1 = 1'b0;
    in_valid_2 = 1'b0; in_inst_2 = '0; in_pc_2 = '0; in_adel_2 = 1'b0;
    #12;
    compare_outputs();
    @(negedge clk);
    reset = 1'b1;
    idle(2'd0);

    // First pair, then fill to full and offer one pair too many.
    step(1'b1, mk(32'hbfc00000, 1'b0), 1'b1, mk(32'hbfc00004, 1'b0), 2'd0, 1'b0);
    for (int i = 1; i < 4; i++)
      step(1'b1, mk(32'hbfc00000 + 32'(8*i), 1'b0), 1'b1, mk(32'hbfc00004 + 32'(8*i), 1'b1), 2'd0, 1'b0);
    step(1'b1, mk(32'hdead0000, 1'b0), 1'b1, mk(32'hdead0004, 1'b0), 2'd0, 1'b0);
    idle(2'd1);
    idle(2'd1);

    // Walk head to entry 7 with two entries left straddling the wrap.
    idle(2'd2);
    idle(2'd2);
    idle(2'd1);
    step(1'b1, mk(32'h00001000, 1'b0), 1'b0, 65'h0, 2'd0, 1'b0);
    step(1'b1, mk(32'h00001004, 1'b0), 1'b1, mk(32'h00001008, 1'b0), 2'd2, 1'b0);

    // Build count=5, then flush with a pair offered and a dequeue requested.
    step(1'b1, mk(32'h00002000, 1'b1), 1'b1, mk(32'h00002004, 1'b0), 2'd0, 1'b0);
    step(1'b1, mk(32'h00002008, 1'b0), 1'b0, 65'h0, 2'd0, 1'b0);
    step(1'b1, mk(32'h0000200c, 1'b0), 1'b1, mk(32'h00002010, 1'b0), 2'd2, 1'b1);

    // Lone lane 2 lands at tail and shows as lane 1.
    step(1'b0, 65'h0, 1'b1, mk(32'h80000010, 1'b1), 2'd0, 1'b0);
    idle(2'd3);
    idle(2'd2);

    // Random traffic including clamped dequeues and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), mk($urandom, 1'($urandom_range(0, 1))),
           1'($urandom_range(0, 1)), mk($urandom, 1'($urandom_range(0, 1))),
           2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset in the middle of the high phase.
    step(1'b1, mk(32'h00003000, 1'b0), 1'b1, mk(32'h00003004, 1'b0), 2'd0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    sb.delete();
    compare_outputs();
    @(negedge clk);
    reset = 1'b1;
    idle(2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
Dual-lane instruction queue between the second fetch stage and decode/issue. Accepts up to two fetched instructions per cycle (pc/pc+4 pair) and presents the two oldest to the ID stage. Decouples fetch from issue stalls, so that a single-issue cycle in ID does not stall fetch. Flushed on branch redirect, interrupt, or exception clean.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4.
PTR_W, 3, log2(DEPTH); derived, not overridden.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  discard all entries and this cycle's enqueue
in_valid_1  input  1  lane-1 (older) instruction valid
in_inst_1  input  32  lane-1 instruction word
in_pc_1  input  32  lane-1 PC
in_adel_1  input  1  lane-1 fetch address-error flag
in_valid_2  input  1  lane-2 (younger) instruction valid
in_inst_2  input  32  lane-2 instruction word
in_pc_2  input  32  lane-2 PC
in_adel_2  input  1  lane-2 fetch address-error flag
in_ready  output  1  at least two free entries
deq_num  input  2  instructions consumed by ID this cycle (0, 1 or 2)
out_valid_1  output  1  head entry valid
out_inst_1  output  32  head instruction; 0 when invalid
out_pc_1  output  32  head PC; 0 when invalid
out_adel_1  output  1  head address-error flag
out_valid_2  output  1  head+1 entry valid
out_inst_2  output  32  head+1 instruction; 0 when invalid
out_pc_2  output  32  head+1 PC; 0 when invalid
out_adel_2  output  1  head+1 address-error flag
count  output  PTR_W+1  current occupancy

Behaviour:
- Reset (reset==0, asynchronous): head=0, tail=0, count=0. All out_* = 0. in_ready=1. Storage contents don't care.
- in_ready = (count <= DEPTH-2), combinational from count.
- Enqueue occurs on rising clk when in_ready && !flush.
  - Valid lanes are written compacted at tail, lane 1 first. A lone valid lane 2 goes to tail.
  - enq = in_valid_1 + in_valid_2. tail advances by enq, modulo DEPTH.
  - If in_ready==0, both lanes are ignored. Upstream holds its data.
- Dequeue: deq_eff = min(deq_num, count). head advances by deq_eff, modulo DEPTH.
  - deq_num > count is clamped, not an error.
  - deq_num==3 is treated as 2.
- Same cycle: count_next = count + enq - deq_eff. Full and empty boundaries are exact. A full queue dequeuing 2 while enqueuing is legal only if in_ready was 1 that cycle.
- Outputs, base build: combinational reads of storage.
  - out_valid_1 = count>=1; out_valid_2 = count>=2.
  - Invalid lanes drive zeros (instruction 0 = NOP).
  - Enqueue-to-output latency: 1 cycle.
- flush (highest priority): next edge head=tail=count=0. Enqueue and dequeue in that cycle are discarded. Outputs are invalid the following cycle.
- Pointer wrap: head+1 is read modulo DEPTH. The entry pair may straddle index DEPTH-1 to 0.
- Reset mid-operation: immediate clear, independent of clk.

Optional Feature:
INST_QUEUE_BYPASS_EN
- Defined: when count==0 && !flush, the out_* lanes mirror the in_* lanes combinationally. out_valid_x = in_valid_x, with the same compaction rule. deq_eff consumes bypassed instructions directly; only unconsumed lanes are written. Latency is 0 cycles when empty. in_ready stays 1 at count==0.
- Undefined: no bypass; 1-cycle latency always.

Decomposition:
- Shared constants header: NOP word (32'h0), DEPTH default, lane-record bit layout {adel, pc[31:0], inst[31:0]} = 65 bits.
- One sub-module: inst_queue_ram, a DEPTH x 65 register file with 2 write ports (tail, tail+1) and 2 read ports (head, head+1). The top level holds pointers, count, clamping, flush and bypass.

Test Plan:
- Reset then idle: count=0, in_ready=1, out_valid_1/2=0, out_inst_1/2=0.
- Enqueue pc 0xbfc00000/0xbfc00004 with deq_num=0: next cycle count=2, out_pc_1=0xbfc00000, out_pc_2=0xbfc00004.
- Fill DEPTH=8 with 4 dual enqueues, deq_num=0: count=8, in_ready=0. A 5th offered pair is dropped and count stays 8. Then deq_num=1 gives count=7, in_ready=0. deq_num=1 again gives count=6, in_ready=1.
- Wrap: head=7, count=2 gives out_pc_1 from entry 7 and out_pc_2 from entry 0. deq_num=2 with dual enqueue leaves count=2 and head=1.
- flush asserted with count=5 and a valid pair offered plus deq_num=2: next cycle count=0, outputs zero, the offered pair is not stored.
- Single lane: only in_valid_2 with pc 0x80000010 is written to entry tail. out_valid_1=1, out_pc_1=0x80000010, in_adel_2=1 propagates to out_adel_1=1. Async reset asserted mid-cycle clears count to 0 before the next edge.
